// File: rtl/rx_fifo_buf_if.sv
// Receive-buffer bus: receiver load side and host read side grouped together.
interface rx_fifo_buf_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 load_buffer;
  logic [DATA_BITS-1:0] packet_data;
  logic                 stop_bit;
  logic                 data_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;
  logic [CNT_W-1:0]     count;

  // Driver side: receiver control unit plus host.
  modport master (
    output load_buffer, packet_data, stop_bit, data_read,
    input  rx_data, data_ready, overrun_error, framing_error, count
  );

  // Buffer side.
  modport slave (
    input  load_buffer, packet_data, stop_bit, data_read,
    output rx_data, data_ready, overrun_error, framing_error, count
  );
endinterface

// File: rtl/rx_fifo_buf.sv
// UART receive buffer: stop-bit check, small FWFT FIFO, overrun/framing flags.
module rx_fifo_buf #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  rx_fifo_buf_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_q, framing_d;
  logic                 push_c, pop_c, full_c, valid_load_c;

  // Push/pop decisions and next-state for pointers, count and flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;
    full_c       = (count_q == CNT_W'(DEPTH));
    valid_load_c = bus.load_buffer & bus.stop_bit;
    pop_c        = bus.data_read & (count_q != '0);
    push_c       = valid_load_c & (~full_c | pop_c);

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);

    // Set has priority over the pop-driven clear.
    if (valid_load_c && full_c && !pop_c) overrun_d = 1'b1;
    else if (pop_c)                       overrun_d = 1'b0;

    // Any load updates the framing flag; stop_bit=0 sets, stop_bit=1 clears.
    if (bus.load_buffer) framing_d = ~bus.stop_bit;
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      framing_q <= framing_d;
    end
  end

  // Storage array; only the write-pointer entry changes on a push.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= bus.packet_data;
    end
  end

  // Outputs derive only from registered state.
  assign bus.rx_data       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.data_ready    = (count_q != '0);
  assign bus.overrun_error = overrun_q;
  assign bus.framing_error = framing_q;
  assign bus.count         = count_q;

endmodule

// File: tb/tb_rx_fifo_buf.sv
// Directed bench for rx_fifo_buf with a queue-based reference model.
module tb_rx_fifo_buf;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned DEPTH     = 4;

  logic clk;
  logic n_rst;

  rx_fifo_buf_if #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) bus ();

  rx_fifo_buf #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_frm;
  bit         check_en;

  int errors;
  int checks;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of receiver/host activity to the model.
  task automatic model_step(input bit l, input bit s, input logic [7:0] d, input bit r);
    bit pop, push, ovr_set;
    pop     = r && (mq.size() > 0);
    push    = l && s && ((mq.size() < DEPTH) || pop);
    ovr_set = l && s && (mq.size() == DEPTH) && !pop;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(d);
    if (ovr_set)  m_ovr = 1'b1;
    else if (pop) m_ovr = 1'b0;
    if (l) m_frm = !s;
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovr = 1'b0;
    m_frm = 1'b0;
  endtask

  // Drive one cycle; returns at posedge+1 with inputs idle.
  task automatic step(input bit l, input logic [7:0] d, input bit s, input bit r);
    bus.load_buffer = l;
    bus.packet_data = d;
    bus.stop_bit    = s;
    bus.data_read   = r;
    @(posedge clk);
    model_step(l, s, d, r);
    #1;
    bus.load_buffer = 1'b0;
    bus.packet_data = '0;
    bus.stop_bit    = 1'b0;
    bus.data_read   = 1'b0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model.rx_data", int'(bus.rx_data), (mq.size() > 0) ? int'(mq[0]) : 0);
      chk("model.data_ready", int'(bus.data_ready), int'(mq.size() > 0));
      chk("model.count", int'(bus.count), mq.size());
      chk("model.overrun", int'(bus.overrun_error), int'(m_ovr));
      chk("model.framing", int'(bus.framing_error), int'(m_frm));
    end
  end

  initial begin
    errors   = 0;
    checks   = 0;
    check_en = 1'b0;
    model_clear();
    bus.load_buffer = 1'b0;
    bus.packet_data = '0;
    bus.stop_bit    = 1'b0;
    bus.data_read   = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset then idle.
    chk("reset.rx_data", int'(bus.rx_data), 0);
    chk("reset.data_ready", int'(bus.data_ready), 0);
    chk("reset.count", int'(bus.count), 0);
    chk("reset.overrun", int'(bus.overrun_error), 0);
    chk("reset.framing", int'(bus.framing_error), 0);
    check_en = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("empty_read.count", int'(bus.count), 0);
    chk("empty_read.ready", int'(bus.data_ready), 0);

    // Single byte.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("single.rx_data", int'(bus.rx_data), 'hA5);
    chk("single.ready", int'(bus.data_ready), 1);
    chk("single.count", int'(bus.count), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("single_pop.ready", int'(bus.data_ready), 0);
    chk("single_pop.rx_data", int'(bus.rx_data), 0);

    // Fill and overrun.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    chk("fill.count", int'(bus.count), 4);
    chk("fill.overrun", int'(bus.overrun_error), 0);
    step(1'b1, 8'h05, 1'b1, 1'b0);
    chk("ovr.overrun", int'(bus.overrun_error), 1);
    chk("ovr.count", int'(bus.count), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr.read_order", int'(bus.rx_data), i);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovr.cleared", int'(bus.overrun_error), 0);
    end
    chk("ovr.drained", int'(bus.count), 0);

    // Simultaneous load+read while full.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    chk("full_both.count", int'(bus.count), 4);
    chk("full_both.overrun", int'(bus.overrun_error), 0);
    chk("full_both.head", int'(bus.rx_data), 'h12);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("full_both.last", int'(bus.rx_data), 'h55);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("full_both.empty", int'(bus.count), 0);

    // Empty and simultaneous load+read: read ignored, push lands.
    step(1'b1, 8'h66, 1'b1, 1'b1);
    chk("empty_both.count", int'(bus.count), 1);
    chk("empty_both.rx_data", int'(bus.rx_data), 'h66);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Framing error then recovery.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("frame.flag", int'(bus.framing_error), 1);
    chk("frame.count", int'(bus.count), 0);
    step(1'b1, 8'h7E, 1'b1, 1'b0);
    chk("frame.cleared", int'(bus.framing_error), 0);
    chk("frame.stored", int'(bus.rx_data), 'h7E);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap: 10 bytes streamed with pointers lapping twice.
    step(1'b1, 8'h10, 1'b1, 1'b0);
    step(1'b1, 8'h11, 1'b1, 1'b0);
    for (int i = 2; i < 10; i++) begin
      chk("wrap.order", int'(bus.rx_data), 'h10 + i - 2);
      step(1'b1, 8'(8'h10 + i), 1'b1, 1'b1);
    end
    chk("wrap.count", int'(bus.count), 2);
    chk("wrap.head", int'(bus.rx_data), 'h18);

    // Asynchronous reset mid-cycle with two entries stored.
    #2;
    n_rst = 1'b0;
    model_clear();
    #1;
    chk("areset.rx_data", int'(bus.rx_data), 0);
    chk("areset.ready", int'(bus.data_ready), 0);
    chk("areset.count", int'(bus.count), 0);
    chk("areset.overrun", int'(bus.overrun_error), 0);
    @(negedge clk);
    #1;
    n_rst = 1'b1;
    step(1'b1, 8'h42, 1'b1, 1'b0);
    chk("post_reset.rx_data", int'(bus.rx_data), 'h42);
    chk("post_reset.count", int'(bus.count), 1);
    @(negedge clk);
    #1;

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
